// File: rtl/vslc_timer_pkg.sv
// Shared definitions for the VSLC round-robin timer scheduler: command
// encodings and default sizing.
package vslc_timer_pkg;

  localparam int NUM_CHAN_DEF = 4;
  localparam int CNT_W_DEF    = 10;

  typedef enum logic [1:0] {
    OP_WRITE_A = 2'b00,
    OP_WRITE_B = 2'b01,
    OP_START   = 2'b10,
    OP_STOP    = 2'b11
  } cmd_op_e;

endpackage : vslc_timer_pkg

// File: rtl/vslc_timer_step.sv
// One timer step for a single channel: compare the counter against the
// active phase's period, then either flip phase or count up.
module vslc_timer_step
  import vslc_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] counter,
  input  logic             phase,
  input  logic             wave,
  input  logic [CNT_W-1:0] period_a,
  input  logic [CNT_W-1:0] period_b,
  output logic [CNT_W-1:0] counter_nxt,
  output logic             phase_nxt,
  output logic             wave_nxt
);

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path
    // leaves a value unassigned and no latch is inferred.
    counter_nxt = counter + CNT_W'(1);
    phase_nxt   = phase;
    wave_nxt    = wave;

    if (!phase && counter == period_a) begin
      counter_nxt = '0;
      phase_nxt   = 1'b1;
      wave_nxt    = ~wave;
    end else if (phase && counter == period_b) begin
      counter_nxt = '0;
      phase_nxt   = 1'b0;
      // A zero-length B phase is a pure re-arm: the waveform keeps its level.
      wave_nxt    = (period_b == '0) ? wave : ~wave;
    end
  end

endmodule : vslc_timer_step

// File: rtl/tt_um_jimktrains_vslc_timer_sched.sv
// Multi-channel two-phase timer. Ticks are latched per channel as pending
// work and drained by a single step datapath visited round-robin.
module tt_um_jimktrains_vslc_timer_sched
  import vslc_timer_pkg::*;
#(
  parameter int NUM_CHAN = NUM_CHAN_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(NUM_CHAN)-1:0] cmd_chan,
  input  logic [CNT_W-1:0]            cmd_data,
  output logic [NUM_CHAN-1:0]         timer_enabled,
  output logic [NUM_CHAN-1:0]         timer_output,
  output logic [NUM_CHAN-1:0]         timer_overrun
);

  localparam int CH_W = $clog2(NUM_CHAN);

  logic [CH_W-1:0]     ptr;
  logic [CNT_W-1:0]    period_a [NUM_CHAN];
  logic [CNT_W-1:0]    period_b [NUM_CHAN];
  logic [CNT_W-1:0]    counter  [NUM_CHAN];
  logic [NUM_CHAN-1:0] phase;
  logic [NUM_CHAN-1:0] wave;
  logic [NUM_CHAN-1:0] enabled;
  logic [NUM_CHAN-1:0] pending;
  logic [NUM_CHAN-1:0] overrun;

  logic                cmd_acc;
  cmd_op_e             op;
  logic                service;
  logic [NUM_CHAN-1:0] svc_sel;
  logic [NUM_CHAN-1:0] cmd_sel;

  logic [CNT_W-1:0]    counter_nxt;
  logic                phase_nxt;
  logic                wave_nxt;

  // Ready is simply "out of reset": every command retires in its own cycle.
  assign cmd_ready = rst_n;
  assign cmd_acc   = cmd_valid & cmd_ready;
  assign op        = cmd_op_e'(cmd_op);

  // A command cycle freezes the scan so command and step never touch the
  // same channel state in one cycle.
  assign service = !cmd_acc && enabled[ptr] && pending[ptr];

  always_comb begin
    svc_sel = '0;
    cmd_sel = '0;
    if (service) svc_sel[ptr]      = 1'b1;
    if (cmd_acc) cmd_sel[cmd_chan] = 1'b1;
  end

  vslc_timer_step #(
    .CNT_W (CNT_W)
  ) u_step (
    .counter     (counter[ptr]),
    .phase       (phase[ptr]),
    .wave        (wave[ptr]),
    .period_a    (period_a[ptr]),
    .period_b    (period_b[ptr]),
    .counter_nxt (counter_nxt),
    .phase_nxt   (phase_nxt),
    .wave_nxt    (wave_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      // NOTE: the per-channel arrays are a handful of flops, not a RAM, so
      // they are reset with everything else; periods must read 0 after reset.
      for (int c = 0; c < NUM_CHAN; c++) begin
        period_a[c] <= '0;
        period_b[c] <= '0;
        counter[c]  <= '0;
      end
      phase   <= '0;
      wave    <= '0;
      enabled <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments, so every read
      // in this block sees the value from before the clock edge.
      if (!cmd_acc) ptr <= ptr + CH_W'(1);

      for (int c = 0; c < NUM_CHAN; c++) begin
        // A tick arriving in the service cycle re-arms pending rather than
        // being lost.
        if (enabled[c] && tick) begin
          pending[c] <= 1'b1;
          if (pending[c] && !svc_sel[c]) overrun[c] <= 1'b1;
        end else if (svc_sel[c]) begin
          pending[c] <= 1'b0;
        end

        if (svc_sel[c]) begin
          counter[c] <= counter_nxt;
          phase[c]   <= phase_nxt;
          wave[c]    <= wave_nxt;
        end

        // Commands come last so they win over tick capture on their target.
        if (cmd_sel[c]) begin
          case (op)
            OP_WRITE_A: period_a[c] <= cmd_data;
            OP_WRITE_B: period_b[c] <= cmd_data;
            OP_START: begin
              enabled[c] <= 1'b1;
              counter[c] <= '0;
              phase[c]   <= 1'b0;
              wave[c]    <= 1'b0;
              pending[c] <= 1'b0;
              overrun[c] <= 1'b0;
            end
            OP_STOP: begin
              enabled[c] <= 1'b0;
              phase[c]   <= 1'b0;
              wave[c]    <= 1'b0;
              pending[c] <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign timer_enabled = enabled;
  assign timer_output  = wave;
  assign timer_overrun = overrun;

endmodule : tt_um_jimktrains_vslc_timer_sched

// File: tb/tb_tt_um_jimktrains_vslc_timer_sched.sv
// Self-checking bench for the VSLC timer scheduler: table-driven waveform
// vectors through a scoreboard queue, plus hand-written corner sequences.
module tb_tt_um_jimktrains_vslc_timer_sched;
  import vslc_timer_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           tick;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [1:0]     cmd_chan;
  logic [CW-1:0]  cmd_data;
  logic [NCH-1:0] timer_enabled;
  logic [NCH-1:0] timer_output;
  logic [NCH-1:0] timer_overrun;

  tt_um_jimktrains_vslc_timer_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_chan      (cmd_chan),
    .cmd_data      (cmd_data),
    .timer_enabled (timer_enabled),
    .timer_output  (timer_output),
    .timer_overrun (timer_overrun)
  );

  always #5 clk = ~clk;

  // Independent model of the scan pointer: advances every cycle without a command.
  logic [1:0] tb_ptr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tb_ptr <= '0;
    else if (!cmd_valid) tb_ptr <= tb_ptr + 2'd1;
  end

  typedef struct {
    int            chan;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    int            n_ticks;
    logic [15:0]   exp_seq;   // bit i = output after tick i+1
    string         name;
  } wave_vec_t;

  typedef struct {
    int    chan;
    logic  exp;
    string name;
  } sb_t;

  wave_vec_t vecs [4];
  sb_t       sb_q [$];
  int        n_tests = 0;
  int        n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] op, input int ch, input logic [CW-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_chan  = ch[1:0];
    cmd_data  = data;
    cycle();
    cmd_valid = 1'b0;
  endtask

  // One tick cycle, expectation queued, then enough idle cycles for the scan to visit every channel.
  task automatic tick_and_expect(input int ch, input logic exp, input string name);
    sb_t e;
    tick = 1'b1;
    e.chan = ch;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    cycle();
    tick = 1'b0;
    repeat (NCH) cycle();
  endtask

  task automatic sb_pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.name, 32'(timer_output[e.chan]), 32'(e.exp));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] ovr_exp;
    int             p;
    int             guard;

    vecs[0] = '{0, 10'd2, 10'd3, 11, 16'h063C, "ch0_a2_b3"};
    vecs[1] = '{1, 10'd1, 10'd0,  6, 16'h000E, "ch1_a1_b0"};
    vecs[2] = '{2, 10'd0, 10'd2,  8, 16'h0077, "ch2_a0_b2"};
    vecs[3] = '{3, 10'd0, 10'd0,  6, 16'h0033, "ch3_a0_b0"};

    rst_n = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_chan = '0; cmd_data = '0;
    #1;
    check("reset_ready",   32'(cmd_ready),     32'd0);
    check("reset_enabled", 32'(timer_enabled), 32'd0);
    check("reset_output",  32'(timer_output),  32'd0);
    check("reset_overrun", 32'(timer_overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // Waveform vectors.
    foreach (vecs[v]) begin
      do_cmd(OP_WRITE_A, vecs[v].chan, vecs[v].a);
      do_cmd(OP_WRITE_B, vecs[v].chan, vecs[v].b);
      do_cmd(OP_START,   vecs[v].chan, '0);
      check({vecs[v].name, "_enabled"}, 32'(timer_enabled[vecs[v].chan]), 32'd1);
      check({vecs[v].name, "_start_out"}, 32'(timer_output[vecs[v].chan]), 32'd0);
      for (int i = 0; i < vecs[v].n_ticks; i++) begin
        tick_and_expect(vecs[v].chan, vecs[v].exp_seq[i], $sformatf("%s_tick%0d", vecs[v].name, i + 1));
        sb_pop_check();
      end
      check({vecs[v].name, "_no_overrun"}, 32'(timer_overrun[vecs[v].chan]), 32'd0);
      do_cmd(OP_STOP, vecs[v].chan, '0);
      check({vecs[v].name, "_stop_out"}, 32'(timer_output[vecs[v].chan]), 32'd0);
      check({vecs[v].name, "_stop_en"},  32'(timer_enabled[vecs[v].chan]), 32'd0);
    end

    // Overrun: two back-to-back ticks; only the channel serviced between them escapes.
    for (int c = 0; c < NCH; c++) do_cmd(OP_START, c, '0);
    repeat (NCH) cycle();
    tick = 1'b1;
    cycle();
    p = int'(tb_ptr);
    cycle();
    tick = 1'b0;
    ovr_exp = 4'hF & ~(4'b0001 << p);
    check("overrun_pattern", 32'(timer_overrun), 32'(ovr_exp));
    repeat (2 * NCH) cycle();
    do_cmd(OP_START, 2, '0);
    check("overrun_start_ch2", 32'(timer_overrun), 32'(ovr_exp & 4'b1011));
    for (int c = 0; c < NCH; c++) do_cmd(OP_STOP, c, '0);
    check("overrun_kept_on_stop", 32'(timer_overrun), 32'(ovr_exp & 4'b1011));
    check("all_stopped", 32'(timer_enabled), 32'd0);

    // Stop during phase 1.
    do_cmd(OP_WRITE_A, 0, 10'd0);
    do_cmd(OP_WRITE_B, 0, 10'd5);
    do_cmd(OP_START,   0, '0);
    tick_and_expect(0, 1'b1, "ph1_enter");
    sb_pop_check();
    tick_and_expect(0, 1'b1, "ph1_hold");
    sb_pop_check();
    do_cmd(OP_STOP, 0, '0);
    check("stop_ph1_out", 32'(timer_output[0]),  32'd0);
    check("stop_ph1_en",  32'(timer_enabled[0]), 32'd0);
    for (int i = 0; i < 3; i++) tick_and_expect(0, 1'b0, $sformatf("stopped_tick%0d", i));
    for (int i = 0; i < 3; i++) sb_pop_check();

    // Stall: tick lands just before ch1's slot, then three commands freeze the scan.
    do_cmd(OP_WRITE_A, 1, 10'd0);
    do_cmd(OP_WRITE_B, 1, 10'd0);
    do_cmd(OP_START,   1, '0);
    guard = 0;
    while (tb_ptr != 2'd0 && guard < 8) begin
      cycle();
      guard++;
    end
    check("stall_align", 32'(tb_ptr), 32'd0);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE_A;
      cmd_chan  = 2'd3;
      cmd_data  = 10'(i + 1);
      #1;
      check($sformatf("stall_ready%0d", i), 32'(cmd_ready), 32'd1);
      cycle();
      check($sformatf("stall_hold%0d", i), 32'(timer_output[1]), 32'd0);
    end
    cmd_valid = 1'b0;
    cycle();
    check("stall_step_done", 32'(timer_output[1]), 32'd1);
    do_cmd(OP_STOP, 1, '0);

    // Asynchronous reset mid-run, then periods must read back as zero.
    do_cmd(OP_WRITE_A, 0, 10'd7);
    do_cmd(OP_WRITE_B, 0, 10'd7);
    do_cmd(OP_START,   0, '0);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("pre_reset_enabled", 32'(timer_enabled[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready",   32'(cmd_ready),     32'd0);
    check("async_rst_enabled", 32'(timer_enabled), 32'd0);
    check("async_rst_output",  32'(timer_output),  32'd0);
    check("async_rst_overrun", 32'(timer_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(OP_START, 0, '0);
    tick_and_expect(0, 1'b1, "post_rst_step1");
    sb_pop_check();
    tick_and_expect(0, 1'b1, "post_rst_step2");
    sb_pop_check();
    tick_and_expect(0, 1'b0, "post_rst_step3");
    sb_pop_check();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tt_um_jimktrains_vslc_timer_sched
